// File: rtl/fetch_stage.sv
// fetch_stage
// ----------------------------------------------------------------------------
// Instruction fetch stage sitting directly upstream of the instruction buffer.
// Keeps the fetch PC and issues one 8-byte (two-instruction) request at a time
// to instruction memory. It attaches the branch-predictor results sampled with
// the request and steers the next PC from those predictions. It presents a
// registered two-slot bundle to the buffer and holds it while stall_if is high.
// A backend redirect reloads the PC, kills the in-flight fetch and clears the
// bundle.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where both
// valid and ready are high. The producer keeps valid and its payload stable
// until that edge. For imem_req, imem_req_valid/imem_req_ready form the pair.
// For the bundle, out_valid != 0 acts as valid and !stall_if acts as ready.
// imem_resp_valid is a one-cycle strobe with no back-pressure.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   redirect_valid, redirect_pc   backend redirect/flush and its target
//   imem_req_valid/ready/addr     request channel to instruction memory
//   imem_resp_valid/data          response (low half = inst at addr,
//                                 high half = inst at addr+4)
//   bp_pc                         predictor lookup PC (= fetch PC)
//   bp_taken_*/bp_target_*        per-slot predictions
//   bp_hist                       predictor history snapshot
//   stall_if                      buffer cannot accept the bundle
//   out_*                         registered two-slot bundle to the buffer
// ----------------------------------------------------------------------------
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                GHR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_resp_valid,
    input  logic [2*INST_W-1:0] imem_resp_data,
    output logic [ADDR_W-1:0]   bp_pc,
    input  logic                bp_taken_0,
    input  logic                bp_taken_1,
    input  logic [ADDR_W-1:0]   bp_target_0,
    input  logic [ADDR_W-1:0]   bp_target_1,
    input  logic [GHR_W-1:0]    bp_hist,
    input  logic                stall_if,
    output logic [1:0]          out_valid,
    output logic [INST_W-1:0]   out_inst_0,
    output logic [INST_W-1:0]   out_inst_1,
    output logic [ADDR_W-1:0]   out_pc_0,
    output logic [ADDR_W-1:0]   out_pc_1,
    output logic                out_pred_taken_0,
    output logic                out_pred_taken_1,
    output logic [ADDR_W-1:0]   out_pred_target_0,
    output logic [ADDR_W-1:0]   out_pred_target_1,
    output logic [GHR_W-1:0]    out_pred_hist_0,
    output logic [GHR_W-1:0]    out_pred_hist_1
);

    // SEND: may issue a request. WAIT: request outstanding, response wanted.
    // DROP: request outstanding but killed by a redirect, response discarded.
    typedef enum logic [1:0] {
        S_SEND = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;

    // Pending record: what was sampled when the outstanding request was taken.
    logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
    logic                pend_taken_0_q, pend_taken_0_d;
    logic                pend_taken_1_q, pend_taken_1_d;
    logic [ADDR_W-1:0]   pend_target_0_q, pend_target_0_d;
    logic [ADDR_W-1:0]   pend_target_1_q, pend_target_1_d;
    logic [GHR_W-1:0]    pend_hist_q, pend_hist_d;

    // Output bundle register.
    logic [1:0]          out_valid_q, out_valid_d;
    logic [INST_W-1:0]   out_inst_0_q, out_inst_0_d;
    logic [INST_W-1:0]   out_inst_1_q, out_inst_1_d;
    logic [ADDR_W-1:0]   out_pc_0_q, out_pc_0_d;
    logic [ADDR_W-1:0]   out_pc_1_q, out_pc_1_d;
    logic                out_pred_taken_0_q, out_pred_taken_0_d;
    logic                out_pred_taken_1_q, out_pred_taken_1_d;
    logic [ADDR_W-1:0]   out_pred_target_0_q, out_pred_target_0_d;
    logic [ADDR_W-1:0]   out_pred_target_1_q, out_pred_target_1_d;
    logic [GHR_W-1:0]    out_pred_hist_0_q, out_pred_hist_0_d;
    logic [GHR_W-1:0]    out_pred_hist_1_q, out_pred_hist_1_d;

    logic                out_free;
    logic                req_valid;
    logic                req_fire;
    logic                slot1_valid;

    always_comb begin
        state_d             = state_q;
        fetch_pc_d          = fetch_pc_q;
        pend_pc_d           = pend_pc_q;
        pend_taken_0_d      = pend_taken_0_q;
        pend_taken_1_d      = pend_taken_1_q;
        pend_target_0_d     = pend_target_0_q;
        pend_target_1_d     = pend_target_1_q;
        pend_hist_d         = pend_hist_q;
        out_valid_d         = out_valid_q;
        out_inst_0_d        = out_inst_0_q;
        out_inst_1_d        = out_inst_1_q;
        out_pc_0_d          = out_pc_0_q;
        out_pc_1_d          = out_pc_1_q;
        out_pred_taken_0_d  = out_pred_taken_0_q;
        out_pred_taken_1_d  = out_pred_taken_1_q;
        out_pred_target_0_d = out_pred_target_0_q;
        out_pred_target_1_d = out_pred_target_1_q;
        out_pred_hist_0_d   = out_pred_hist_0_q;
        out_pred_hist_1_d   = out_pred_hist_1_q;

        // The register is free if empty or being accepted this cycle. Only
        // issuing while it is free guarantees the response always has room.
        out_free    = (out_valid_q == 2'b00) || !stall_if;
        // rst_n gates the strobe so it stays low for the whole reset period.
        req_valid   = rst_n && (state_q == S_SEND) && out_free && !redirect_valid;
        req_fire    = req_valid && imem_req_ready;
        slot1_valid = !pend_taken_0_q;

        if ((out_valid_q != 2'b00) && !stall_if) begin
            out_valid_d = 2'b00;
        end

        case (state_q)
            S_SEND: begin
                if (req_fire) begin
                    state_d         = S_WAIT;
                    pend_pc_d       = fetch_pc_q;
                    pend_taken_0_d  = bp_taken_0;
                    pend_taken_1_d  = bp_taken_1;
                    pend_target_0_d = bp_target_0;
                    pend_target_1_d = bp_target_1;
                    pend_hist_d     = bp_hist;
                    if (bp_taken_0) begin
                        fetch_pc_d = bp_target_0;
                    end else if (bp_taken_1) begin
                        fetch_pc_d = bp_target_1;
                    end else begin
                        fetch_pc_d = fetch_pc_q + ADDR_W'(8);
                    end
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    // A redirect in this same cycle still consumes the
                    // response; the clear further down discards the data.
                    state_d             = S_SEND;
                    out_valid_d         = {slot1_valid, 1'b1};
                    out_pc_0_d          = pend_pc_q;
                    out_inst_0_d        = imem_resp_data[INST_W-1:0];
                    out_pred_taken_0_d  = pend_taken_0_q;
                    out_pred_target_0_d = pend_target_0_q;
                    out_pred_hist_0_d   = pend_hist_q;
                    out_pc_1_d          = slot1_valid ? pend_pc_q + ADDR_W'(4) : '0;
                    out_inst_1_d        = slot1_valid ? imem_resp_data[2*INST_W-1:INST_W] : '0;
                    out_pred_taken_1_d  = slot1_valid ? pend_taken_1_q : 1'b0;
                    out_pred_target_1_d = slot1_valid ? pend_target_1_q : '0;
                    out_pred_hist_1_d   = slot1_valid ? pend_hist_q : '0;
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                // The killed request's response closes the transaction even if
                // another redirect lands in the same cycle; waiting on would
                // hang since no further response is coming.
                if (imem_resp_valid) begin
                    state_d = S_SEND;
                end
            end
            default: begin
                state_d = S_SEND;
            end
        endcase

        if (redirect_valid) begin
            fetch_pc_d          = redirect_pc;
            out_valid_d         = 2'b00;
            out_inst_0_d        = '0;
            out_inst_1_d        = '0;
            out_pc_0_d          = '0;
            out_pc_1_d          = '0;
            out_pred_taken_0_d  = 1'b0;
            out_pred_taken_1_d  = 1'b0;
            out_pred_target_0_d = '0;
            out_pred_target_1_d = '0;
            out_pred_hist_0_d   = '0;
            out_pred_hist_1_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= S_SEND;
            fetch_pc_q          <= RESET_PC;
            pend_pc_q           <= '0;
            pend_taken_0_q      <= 1'b0;
            pend_taken_1_q      <= 1'b0;
            pend_target_0_q     <= '0;
            pend_target_1_q     <= '0;
            pend_hist_q         <= '0;
            out_valid_q         <= 2'b00;
            out_inst_0_q        <= '0;
            out_inst_1_q        <= '0;
            out_pc_0_q          <= '0;
            out_pc_1_q          <= '0;
            out_pred_taken_0_q  <= 1'b0;
            out_pred_taken_1_q  <= 1'b0;
            out_pred_target_0_q <= '0;
            out_pred_target_1_q <= '0;
            out_pred_hist_0_q   <= '0;
            out_pred_hist_1_q   <= '0;
        end else begin
            state_q             <= state_d;
            fetch_pc_q          <= fetch_pc_d;
            pend_pc_q           <= pend_pc_d;
            pend_taken_0_q      <= pend_taken_0_d;
            pend_taken_1_q      <= pend_taken_1_d;
            pend_target_0_q     <= pend_target_0_d;
            pend_target_1_q     <= pend_target_1_d;
            pend_hist_q         <= pend_hist_d;
            out_valid_q         <= out_valid_d;
            out_inst_0_q        <= out_inst_0_d;
            out_inst_1_q        <= out_inst_1_d;
            out_pc_0_q          <= out_pc_0_d;
            out_pc_1_q          <= out_pc_1_d;
            out_pred_taken_0_q  <= out_pred_taken_0_d;
            out_pred_taken_1_q  <= out_pred_taken_1_d;
            out_pred_target_0_q <= out_pred_target_0_d;
            out_pred_target_1_q <= out_pred_target_1_d;
            out_pred_hist_0_q   <= out_pred_hist_0_d;
            out_pred_hist_1_q   <= out_pred_hist_1_d;
        end
    end

    assign imem_req_valid    = req_valid;
    assign imem_req_addr     = fetch_pc_q;
    assign bp_pc             = fetch_pc_q;
    assign out_valid         = out_valid_q;
    assign out_inst_0        = out_inst_0_q;
    assign out_inst_1        = out_inst_1_q;
    assign out_pc_0          = out_pc_0_q;
    assign out_pc_1          = out_pc_1_q;
    assign out_pred_taken_0  = out_pred_taken_0_q;
    assign out_pred_taken_1  = out_pred_taken_1_q;
    assign out_pred_target_0 = out_pred_target_0_q;
    assign out_pred_target_1 = out_pred_target_1_q;
    assign out_pred_hist_0   = out_pred_hist_0_q;
    assign out_pred_hist_1   = out_pred_hist_1_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of the instruction buffer. It generates the fetch PC and issues one 2-instruction (8-byte) request at a time to instruction memory. It attaches branch-predictor results and computes the next PC. It presents a registered 2-slot bundle to the buffer, holding it while the buffer asserts stall_if. A redirect from the backend overrides the PC, kills the in-flight fetch and clears the bundle.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset
ADDR_W, 32, instruction address width
INST_W, 32, instruction width
GHR_W, 8, predictor global-history width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
redirect_valid  in  1  backend redirect/flush (same cycle drives buffer flush)
redirect_pc  in  ADDR_W  redirect target
imem_req_valid  out  1  memory request strobe
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  request address (= fetch_pc)
imem_resp_valid  in  1  response strobe, latency >= 1 cycle
imem_resp_data  in  2*INST_W  [INST_W-1:0] inst at addr, upper half inst at addr+4
bp_pc  out  ADDR_W  predictor lookup PC (= fetch_pc), combinational
bp_taken_0 / bp_taken_1  in  1  prediction for slot 0 / slot 1
bp_target_0 / bp_target_1  in  ADDR_W  predicted targets
bp_hist  in  GHR_W  history snapshot for this fetch
stall_if  in  1  buffer cannot accept the presented bundle
out_valid  out  2  slot valids to buffer
out_inst_0 / out_inst_1  out  INST_W  instructions
out_pc_0 / out_pc_1  out  ADDR_W  slot PCs
out_pred_taken_0 / out_pred_taken_1  out  1  predicted taken
out_pred_target_0 / out_pred_target_1  out  ADDR_W  predicted targets
out_pred_hist_0 / out_pred_hist_1  out  GHR_W  history (both = captured bp_hist)

Behaviour:
- Reset: fetch_pc=RESET_PC, state=SEND, out_valid=2'b00, all out_* data=0, imem_req_valid=0 for the whole reset period.
- Reset mid-operation abandons all state immediately; memory shares rst_n, so no stale response follows.
- Bundle accept: accepted when out_valid!=0 && !stall_if. Out_valid and data hold unchanged until accepted.
- out_free = (out_valid==0) || accepted this cycle.
- FSM states: SEND, WAIT, DROP.
- SEND: imem_req_valid = out_free && !redirect_valid.
  - On req_valid && req_ready: capture fetch_pc, bp_taken_0/1, bp_target_0/1, bp_hist into the pending record; go to WAIT.
  - Next fetch_pc = bp_target_0 if bp_taken_0; else bp_target_1 if bp_taken_1; else fetch_pc+8 (modulo 2^ADDR_W).
- WAIT: on imem_resp_valid, write the bundle and go to SEND.
  - slot0: valid, pc=pend_pc, inst=data low half.
  - slot1: valid iff !pend_taken_0, pc=pend_pc+4, inst=data high half.
  - pred fields come from the pending record; slot1 fields are 0 when slot1 is invalid.
  - Bundle is visible the cycle after the response, so fetch latency is memory latency + 1.
  - The output register is guaranteed free: a request is issued only when out_free, and nothing else writes the register.
- DROP: on imem_resp_valid, discard the data and go to SEND. Otherwise stay.
- Redirect (highest priority, any state):
  - fetch_pc <= redirect_pc; out_valid <= 0 next cycle; no request issued this cycle.
  - State: SEND->SEND, WAIT->DROP, DROP->DROP.
  - If imem_resp_valid arrives in the same cycle as redirect in WAIT: discard it and go to SEND.
- imem_resp_valid in SEND is ignored.
- At most one request outstanding. Steady-state throughput is one bundle per (latency+1) cycles.
- imem_req_addr / bp_pc = fetch_pc at all times. No alignment check: slot1 is always at pc+4.

Test Plan:
- Reset, 1-cycle memory, stall_if=0, no predictions -> requests at 0x0, 0x8, 0x10; bundles out_valid=2'b11 with out_pc_0/out_pc_1 = 0x0/0x4, then 0x8/0xC, in order.
- bp_taken_0=1, bp_target_0=0x100 on fetch 0x8 -> bundle out_valid=2'b01, out_pred_taken_0=1, out_pred_target_0=0x100; next req addr=0x100. Repeat with bp_taken_1=1, target 0x200 -> out_valid=2'b11, next req 0x200.
- Hold stall_if=1 for 3 cycles with a bundle present -> out_* stable, no new request; releasing stall -> bundle accepted and a request is issued in the same cycle.
- redirect_pc=0x400 while in WAIT, response arrives 2 cycles later -> response discarded, next request addr=0x400, out_valid=0 from the cycle after the redirect.
- Redirect coincident with imem_resp_valid -> data dropped, state SEND; request for redirect_pc in the next cycle.
- Assert rst_n low mid-WAIT -> out_valid=0 and imem_req_valid=0 immediately; after release, first request is at RESET_PC.
- imem_req_ready=0 for 4 cycles -> req_valid and addr held constant; no state change until ready.
